// File: rtl/fp16_to_int_top.sv
// Half-float to 16-bit sign-magnitude integer converter with embedded byte memory (dm1).
// Optional half-up rounding of the magnitude is enabled by defining FLT2INT_ROUND_EN.

module fp16_dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] my_memory [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) my_memory[waddr_i] <= wdata_i;
    end

    assign rdata_o = my_memory[raddr_i];
endmodule

// state  | meaning
// IDLE   | held in reset / first clk after release
// RDHI   | latch float MSB
// RDLO   | latch float LSB
// DECODE | classify exponent, load accumulator and shift count
// SHIFT  | one-bit shift of the accumulator per clk
// ROUND  | half-up rounding of magnitude (FLT2INT_ROUND_EN only)
// WRHI   | store result MSB
// WRLO   | store result LSB
// DONE   | result stored, done held until reset
module fp16_to_int_top #(
    parameter int MEM_DEPTH = 256,
    parameter int IN_ADDR   = 64,
    parameter int OUT_ADDR  = 66
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] pMux,
    output logic       done
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RDHI,
        ST_RDLO,
        ST_DECODE,
        ST_SHIFT,
`ifdef FLT2INT_ROUND_EN
        ST_ROUND,
`endif
        ST_WRHI,
        ST_WRLO,
        ST_DONE
    } state_e;

`ifdef FLT2INT_ROUND_EN
    localparam state_e ST_POST = ST_ROUND;
`else
    localparam state_e ST_POST = ST_WRHI;
`endif

    state_e      state_q, state_d;
    logic [7:0]  fhi_q, fhi_d, flo_q, flo_d;
    logic        sign_q, sign_d;
    logic [14:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
`ifdef FLT2INT_ROUND_EN
    logic        round_q, round_d;
    logic [15:0] sum_w;
`endif

    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic [4:0]    exp_w;

    fp16_dmem #(.DEPTH(MEM_DEPTH), .AW(AW)) dm1 (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign exp_w     = fhi_q[6:2];
    assign mem_raddr = (state_q == ST_RDLO) ? AW'(IN_ADDR + 1) : AW'(IN_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fhi_q   <= '0;
            flo_q   <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
`ifdef FLT2INT_ROUND_EN
            round_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fhi_q   <= fhi_d;
            flo_q   <= flo_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
`ifdef FLT2INT_ROUND_EN
            round_q <= round_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        fhi_d     = fhi_q;
        flo_d     = flo_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        mem_we    = 1'b0;
        mem_waddr = AW'(OUT_ADDR);
        mem_wdata = {sign_q, acc_q[14:8]};
        done      = 1'b0;
`ifdef FLT2INT_ROUND_EN
        round_d   = round_q;
        sum_w     = {1'b0, acc_q} + 16'(round_q);
`endif
        case (state_q)
            ST_IDLE:  state_d = (pMux == 2'b01) ? ST_RDHI : ST_DONE;
            ST_RDHI: begin
                fhi_d   = mem_rdata;
                state_d = ST_RDLO;
            end
            ST_RDLO: begin
                flo_d   = mem_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                sign_d = fhi_q[7];
                cnt_d  = '0;
                left_d = 1'b0;
`ifdef FLT2INT_ROUND_EN
                round_d = 1'b0;
`endif
                // Biased exponent 25 means unbiased 10: mantissa already integer-aligned.
                if (exp_w >= 5'd30) begin
                    acc_d   = 15'h7FFF;
                    state_d = ST_POST;
                end else if (exp_w < 5'd15) begin
`ifdef FLT2INT_ROUND_EN
                    acc_d = (exp_w == 5'd14) ? 15'd1 : 15'd0;
`else
                    acc_d = '0;
`endif
                    state_d = ST_POST;
                end else begin
                    acc_d = {4'b0, 1'b1, fhi_q[1:0], flo_q};
                    if (exp_w < 5'd25) begin
                        cnt_d   = 4'(5'd25 - exp_w);
                        state_d = ST_SHIFT;
                    end else if (exp_w > 5'd25) begin
                        cnt_d   = 4'(exp_w - 5'd25);
                        left_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = left_q ? {acc_q[13:0], 1'b0} : {1'b0, acc_q[14:1]};
`ifdef FLT2INT_ROUND_EN
                round_d = ~left_q & acc_q[0];
`endif
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_POST;
            end
`ifdef FLT2INT_ROUND_EN
            ST_ROUND: begin
                acc_d   = sum_w[15] ? 15'h7FFF : sum_w[14:0];
                state_d = ST_WRHI;
            end
`endif
            ST_WRHI: begin
                mem_we  = 1'b1;
                state_d = ST_WRLO;
            end
            ST_WRLO: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(OUT_ADDR + 1);
                mem_wdata = acc_q[7:0];
                state_d   = ST_DONE;
            end
            ST_DONE:  done = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp16_to_int_top.sv
// Self-checking bench for fp16_to_int_top (truncation build): directed, random, abort and no-op runs.
// The reference model evaluates the half float as a real number and truncates it.

module tb_fp16_to_int_top;
    localparam int IN_ADDR  = 64;
    localparam int OUT_ADDR = 66;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] pMux  = 2'b01;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    fp16_to_int_top dut (
        .clk   (clk),
        .reset (reset),
        .pMux  (pMux),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic real fp_abs(input logic [15:0] f);
        int ex = int'(f[14:10]);
        int fr = int'(f[9:0]);
        if (ex == 0) return real'(fr) * (2.0 ** real'(-24));
        return real'(1024 + fr) * (2.0 ** real'(ex - 25));
    endfunction

    function automatic logic [15:0] golden(input logic [15:0] f);
        real v = fp_abs(f);
        int  mag;
        if (f[14:10] == 5'd31 || v > 32767.0) mag = 32767;
        else mag = $rtoi(v);
        return {f[15], mag[14:0]};
    endfunction

    // Clocks from release to done: six fixed steps plus |e-10| shifts when 0<=e<=14.
    function automatic int exp_lat(input logic [15:0] f);
        int ex = int'(f[14:10]);
        if (ex >= 15 && ex <= 29) return 6 + ((ex > 25) ? ex - 25 : 25 - ex);
        return 6;
    endfunction

    function automatic logic [15:0] mem_result();
        return {dut.dm1.my_memory[OUT_ADDR], dut.dm1.my_memory[OUT_ADDR + 1]};
    endfunction

    task automatic load(input logic [15:0] f, input logic [15:0] sentinel);
        dut.dm1.my_memory[IN_ADDR]      = f[15:8];
        dut.dm1.my_memory[IN_ADDR + 1]  = f[7:0];
        dut.dm1.my_memory[OUT_ADDR]     = sentinel[15:8];
        dut.dm1.my_memory[OUT_ADDR + 1] = sentinel[7:0];
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic launch(input logic [15:0] f, input logic [1:0] pm, input logic [15:0] sentinel,
                          output int cyc);
        reset = 1'b1;
        pMux  = pm;
        load(f, sentinel);
        #20;
        @(negedge clk);
        reset = 1'b0;
        wait_done(cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pMux  = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b, want 0", done);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vin  [10] = '{16'hC204, 16'hCA10, 16'hD20F, 16'h77FF, 16'h7800,
                                   16'hFC00, 16'h3C00, 16'h3BFF, 16'h0001, 16'h8000};
        logic [15:0] vexp [10] = '{16'h8003, 16'h800C, 16'h8030, 16'h7FF0, 16'h7FFF,
                                   16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000};
        int cyc;
        for (int i = 0; i < 10; i++) begin
            launch(vin[i], 2'b01, 16'h5AA5, cyc);
            n_vec++;
            if (mem_result() !== vexp[i]) begin
                n_err++;
                $display("FAIL directed_result %h: got %h, want %h", vin[i], mem_result(), vexp[i]);
            end
            n_vec++;
            if (cyc !== exp_lat(vin[i]) || cyc > 16) begin
                n_err++;
                $display("FAIL directed_latency %h: got %0d clks, want %0d", vin[i], cyc, exp_lat(vin[i]));
            end
        end
        // Last vector also confirms done stays high with no further writes.
        dut.dm1.my_memory[OUT_ADDR + 1] = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b1 || dut.dm1.my_memory[OUT_ADDR + 1] !== 8'h3C) begin
            n_err++;
            $display("FAIL done_hold: got done=%b lo=%h, want done=1 lo=3c",
                     done, dut.dm1.my_memory[OUT_ADDR + 1]);
        end
    endtask

    task automatic test_random();
        logic [15:0] f;
        logic [15:0] want;
        real         v;
        int          cyc;
        int          mag;
        for (int i = 0; i < 20; i++) begin
            f = 16'($urandom_range(0, 65535));
            if (i % 2 == 0) f[14:10] = 5'($urandom_range(15, 29));
            want = golden(f);
            launch(f, 2'b01, 16'($urandom_range(0, 65535)), cyc);
            n_vec++;
            if (mem_result() !== want || cyc !== exp_lat(f)) begin
                n_err++;
                $display("FAIL random_result %h: got %h in %0d clks, want %h in %0d clks",
                         f, mem_result(), cyc, want, exp_lat(f));
            end
            v   = fp_abs(f);
            mag = int'(mem_result() & 16'h7FFF);
            if (f[14:10] != 5'd31 && v < 32767.0) begin
                n_vec++;
                if (!(v - real'(mag) >= 0.0 && v - real'(mag) < 1.0)) begin
                    n_err++;
                    $display("FAIL random_error %h: got magnitude %0d, want within 1 below %f", f, mag, v);
                end
            end
        end
    endtask

    task automatic test_abort();
        int cyc;
        reset = 1'b1;
        pMux  = 2'b01;
        load(16'hCA10, 16'h1234);
        #20;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (done !== 1'b0 || mem_result() !== 16'h1234) begin
            n_err++;
            $display("FAIL abort_state: got done=%b out=%h, want done=0 out=1234", done, mem_result());
        end
        load(16'h4D00, 16'h1234);
        #20;
        @(negedge clk);
        reset = 1'b0;
        wait_done(cyc);
        n_vec++;
        if (done !== 1'b1 || mem_result() !== 16'h0014) begin
            n_err++;
            $display("FAIL abort_rerun: got done=%b out=%h, want done=1 out=0014", done, mem_result());
        end
    endtask

    task automatic test_noop();
        int cyc;
        launch(16'h4D00, 2'b00, 16'hBEEF, cyc);
        n_vec++;
        if (done !== 1'b1 || cyc > 2) begin
            n_err++;
            $display("FAIL noop_done: got done=%b after %0d clks, want 1 within 2", done, cyc);
        end
        repeat (12) @(posedge clk);
        #1;
        n_vec++;
        if (mem_result() !== 16'hBEEF) begin
            n_err++;
            $display("FAIL noop_mem: got %h, want beef", mem_result());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_noop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
